// File: rtl/des_sched_pkg.sv
// Shared types and default widths for the DES region scheduler.
// Top FSM and per-worker slot states.
package des_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } top_state_t;

  typedef enum logic [1:0] {
    FREE,
    RUNNING,
    HARVEST
  } slot_state_t;

  localparam int NUM_BLOCKS_D = 4;
  localparam int REGION_W_D   = 16;
  localparam int COUNT_W_D    = 48;
  localparam int ACC_W_D      = 64;

endpackage

// File: rtl/des_region_scheduler_if.sv
// Worker bus between the scheduler and its des_block array.
// Master drives start/region, slave returns valid/counter.
interface des_region_scheduler_if
  import des_sched_pkg::*;
#(
  parameter int NUM_BLOCKS = NUM_BLOCKS_D,
  parameter int REGION_W   = REGION_W_D,
  parameter int COUNT_W    = COUNT_W_D
);

  logic [NUM_BLOCKS-1:0]          w_start;
  logic [NUM_BLOCKS*REGION_W-1:0] w_region;
  logic [NUM_BLOCKS-1:0]          w_valid;
  logic [NUM_BLOCKS*COUNT_W-1:0]  w_counter;

  modport master (
    output w_start,
    output w_region,
    input  w_valid,
    input  w_counter
  );

  modport slave (
    input  w_start,
    input  w_region,
    output w_valid,
    output w_counter
  );

endinterface

// File: rtl/des_region_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts
// at the slot after the most recent grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] idx;
  logic [PW-1:0] gidx;
  logic          found;

  always_comb begin
    gnt   = '0;
    gidx  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_q) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gidx     = idx;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (found) begin
      ptr_q <= PW'((int'(gidx) + 1) % N);
    end
  end

endmodule

// File: rtl/des_region_scheduler.sv
// Region dispatcher for parallel des_block workers with
// a single shared accumulator for harvested counters.
module des_region_scheduler
  import des_sched_pkg::*;
#(
  parameter int NUM_BLOCKS = NUM_BLOCKS_D,
  parameter int REGION_W   = REGION_W_D,
  parameter int COUNT_W    = COUNT_W_D,
  parameter int ACC_W      = ACC_W_D
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_start,
  input  logic                cmd_abort,
  input  logic [REGION_W-1:0] region_first,
  input  logic [REGION_W-1:0] region_last,
  des_region_scheduler_if.master w,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [ACC_W-1:0]    total_count,
  output logic [REGION_W:0]   regions_done
);

  localparam int IW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [REGION_W:0] ONE = (REGION_W+1)'(1);

  top_state_t  state_q;
  top_state_t  state_d;
  slot_state_t slot_q [NUM_BLOCKS];

  logic [REGION_W:0]              next_q;
  logic [REGION_W-1:0]            last_q;
  logic [NUM_BLOCKS*REGION_W-1:0] region_q;

  logic                  active;
  logic                  abort_hit;
  logic                  start_ok;
  logic                  more;
  logic                  all_free;
  logic                  disp_vld;
  logic [IW-1:0]         disp_idx;
  logic [NUM_BLOCKS-1:0] free_v;
  logic [NUM_BLOCKS-1:0] req;
  logic [NUM_BLOCKS-1:0] gnt;
  logic [COUNT_W-1:0]    harv;

  assign active    = (state_q == RUN) || (state_q == DRAIN);
  assign abort_hit = cmd_abort && active;
  assign start_ok  = cmd_start && !cmd_abort &&
                     ((state_q == IDLE) || (state_q == DONE));
  // Extra MSB keeps an all-ones region_last from wrapping.
  assign more      = next_q <= {1'b0, last_q};
  assign all_free  = &free_v;

  assign w.w_start  = ~free_v;
  assign w.w_region = region_q;

  always_comb begin
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      free_v[i] = slot_q[i] == FREE;
      req[i]    = (slot_q[i] == HARVEST) && !abort_hit;
    end
  end

  always_comb begin
    disp_idx = '0;
    for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
      if (free_v[i]) disp_idx = IW'(i);
    end
    disp_vld = (|free_v) && (state_q == RUN) &&
               more && !cmd_abort;
  end

  always_comb begin
    harv = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      if (gnt[i]) harv = harv | w.w_counter[i*COUNT_W +: COUNT_W];
    end
  end

  rr_arbiter #(.N(NUM_BLOCKS)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start_ok) state_d = RUN;
      RUN: begin
        if (cmd_abort)  state_d = DONE;
        else if (!more) state_d = DRAIN;
      end
      DRAIN: begin
        if (cmd_abort)     state_d = DONE;
        else if (all_free) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = active;
    done = state_q == DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BLOCKS; i++) slot_q[i] <= FREE;
      region_q <= '0;
    end else begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        unique case (slot_q[i])
          FREE: begin
            if (disp_vld && disp_idx == IW'(i)) begin
              slot_q[i] <= RUNNING;
              region_q[i*REGION_W +: REGION_W] <=
                next_q[REGION_W-1:0];
            end
          end
          RUNNING: if (w.w_valid[i]) slot_q[i] <= HARVEST;
          HARVEST: if (gnt[i])       slot_q[i] <= FREE;
          default: slot_q[i] <= FREE;
        endcase
        if (abort_hit) slot_q[i] <= FREE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_q       <= '0;
      last_q       <= '0;
      total_count  <= '0;
      regions_done <= '0;
      aborted      <= 1'b0;
    end else if (start_ok) begin
      next_q       <= {1'b0, region_first};
      last_q       <= region_last;
      total_count  <= '0;
      regions_done <= '0;
      aborted      <= 1'b0;
    end else if (abort_hit) begin
      aborted <= 1'b1;
    end else begin
      if (disp_vld) next_q <= next_q + ONE;
      if (|gnt) begin
        total_count  <= total_count + ACC_W'(harv);
        regions_done <= regions_done + ONE;
      end
    end
  end

endmodule

// File: tb/tb_des_region_scheduler.sv
// Bench for des_region_scheduler with behavioural
// des_block workers and a range-sum reference model.
module tb_des_region_scheduler;
  import des_sched_pkg::*;

  localparam int NB = 4;
  localparam int RW = 16;
  localparam int CW = 48;
  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_start = 1'b0;
  logic          cmd_abort = 1'b0;
  logic [RW-1:0] region_first = '0;
  logic [RW-1:0] region_last = '0;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [AW-1:0] total_count;
  logic [RW:0]   regions_done;

  des_region_scheduler_if #(
    .NUM_BLOCKS(NB), .REGION_W(RW), .COUNT_W(CW)
  ) wif ();

  des_region_scheduler #(
    .NUM_BLOCKS(NB), .REGION_W(RW),
    .COUNT_W(CW), .ACC_W(AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_start    (cmd_start),
    .cmd_abort    (cmd_abort),
    .region_first (region_first),
    .region_last  (region_last),
    .w            (wif),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .total_count  (total_count),
    .regions_done (regions_done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          lat [NB];
  logic [31:0] kmul = 32'd1;

  logic [NB-1:0] prev;
  int            left [NB];
  logic [RW-1:0] wreg [NB];
  int            disp_cnt [int];
  int            ndisp;
  logic [NB-1:0] ever;
  logic [63:0]   hsum;
  int            hcnt;
  bit            ign = 1'b0;
  int            fallq [$];
  int            fallc [$];
  int            cyc = 0;

  function automatic logic [CW-1:0] f(int r);
    logic [63:0] p;
    p = 64'(r + 1) * 64'(kmul);
    return p[CW-1:0];
  endfunction

  function automatic logic [63:0] ref_sum(int a, int b);
    logic [63:0] s;
    s = '0;
    for (int r = a; r <= b; r++) s += 64'(f(r));
    return s;
  endfunction

  task automatic chk(string tag, logic [63:0] o,
                     logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_sb();
    disp_cnt.delete();
    ndisp = 0;
    ever  = '0;
    hsum  = '0;
    hcnt  = 0;
    fallq.delete();
    fallc.delete();
  endtask

  task automatic pulse_start(int a, int b);
    region_first = RW'(a);
    region_last  = RW'(b);
    cmd_start    = 1'b1;
    step();
    cmd_start    = 1'b0;
  endtask

  task automatic wait_done(int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    chk("done_reached", 64'(done), 64'd1);
  endtask

  task automatic run_range(string tag, int a, int b);
    int n;
    int len;
    int ok;
    len = (b >= a) ? b - a + 1 : 0;
    clear_sb();
    pulse_start(a, b);
    wait_done(3000, n);
    chk({tag, "_regions"}, 64'(regions_done), 64'(len));
    chk({tag, "_total"}, total_count, ref_sum(a, b));
    chk({tag, "_aborted"}, 64'(aborted), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    ok = 0;
    for (int r = a; r <= b; r++)
      if (disp_cnt.exists(r) && disp_cnt[r] == 1) ok++;
    chk({tag, "_disp_once"}, 64'(ok), 64'(len));
    chk({tag, "_disp_total"}, 64'(ndisp), 64'(len));
  endtask

  // Behavioural des_block array plus interface monitor.
  initial begin
    wif.w_valid   = '0;
    wif.w_counter = '0;
    prev          = '0;
    for (int i = 0; i < NB; i++) begin
      left[i] = 0;
      wreg[i] = '0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NB; i++) begin
        if (wif.w_start[i] && !prev[i]) begin
          wreg[i] = wif.w_region[i*RW +: RW];
          if (disp_cnt.exists(int'(wreg[i])))
            disp_cnt[int'(wreg[i])]++;
          else
            disp_cnt[int'(wreg[i])] = 1;
          ndisp++;
          ever[i] = 1'b1;
          left[i] = lat[i];
        end else if (wif.w_start[i]) begin
          chk("region_stable",
              64'(wif.w_region[i*RW +: RW]), 64'(wreg[i]));
          if (left[i] > 0) left[i]--;
          if (left[i] == 0) begin
            wif.w_valid[i] = 1'b1;
            wif.w_counter[i*CW +: CW] = f(int'(wreg[i]));
          end
        end else begin
          if (prev[i] && !ign) begin
            hsum += 64'(f(int'(wreg[i])));
            hcnt++;
            fallq.push_back(i);
            fallc.push_back(cyc);
          end
          wif.w_valid[i] = 1'b0;
          wif.w_counter[i*CW +: CW] = '0;
        end
        prev[i] = wif.w_start[i];
      end
    end
  end

  initial begin
    int n;
    int a;
    int b;
    logic [63:0] es;
    int ec;
    for (int i = 0; i < NB; i++) lat[i] = 3;

    // Reset state
    step();
    step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_aborted", 64'(aborted), 64'd0);
    chk("rst_total", total_count, 64'd0);
    chk("rst_regions", 64'(regions_done), 64'd0);
    chk("rst_wstart", 64'(wif.w_start), 64'd0);
    chk("rst_wregion", 64'(wif.w_region), 64'd0);
    rst_n = 1'b1;
    step();

    // Range 0..9, counter = region+1, with an ignored restart
    kmul = 32'd1;
    for (int i = 0; i < NB; i++) lat[i] = $urandom_range(1, 8);
    clear_sb();
    pulse_start(0, 9);
    step();
    chk("t1_busy", 64'(busy), 64'd1);
    repeat (4) step();
    region_first = 16'd100;
    region_last  = 16'd200;
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    wait_done(3000, n);
    chk("t1_regions", 64'(regions_done), 64'd10);
    chk("t1_total", total_count, 64'd55);
    chk("t1_disp_total", 64'(ndisp), 64'd10);
    a = 0;
    for (int r = 0; r <= 9; r++)
      if (disp_cnt.exists(r) && disp_cnt[r] == 1) a++;
    chk("t1_disp_once", 64'(a), 64'd10);

    // Single region: only slot 0, two-cycle start latency
    clear_sb();
    region_first = 16'd5;
    region_last  = 16'd5;
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    chk("t2_lat1_wstart", 64'(wif.w_start), 64'd0);
    step();
    chk("t2_lat2_wstart", 64'(wif.w_start), 64'b0001);
    chk("t2_wregion0", 64'(wif.w_region[RW-1:0]), 64'd5);
    wait_done(3000, n);
    chk("t2_regions", 64'(regions_done), 64'd1);
    chk("t2_total", total_count, 64'(f(5)));
    chk("t2_ever", 64'(ever), 64'b0001);

    // Top of the region space: no wrap
    kmul = $urandom;
    run_range("t3", 16'hFFFE, 16'hFFFF);
    chk("t3_no_zero", 64'(disp_cnt.exists(0)), 64'd0);

    // All workers valid together: round-robin drain
    for (int i = 0; i < NB; i++) lat[i] = 2 + (NB - 1 - i);
    kmul = $urandom;
    run_range("t4", 0, 3);
    chk("t4_grants", 64'(fallq.size()), 64'd4);
    if (fallq.size() == 4) begin
      for (int k = 1; k < 4; k++) begin
        chk("t4_consec", 64'(fallc[k]), 64'(fallc[k-1] + 1));
        chk("t4_rr_order", 64'(fallq[k]),
            64'((fallq[k-1] + 1) % NB));
      end
    end

    // Randomized ranges, latencies and counter scaling
    for (int t = 0; t < 6; t++) begin
      a = $urandom_range(0, 65535);
      b = a + $urandom_range(0, 20);
      if (b > 65535) b = 65535;
      kmul = $urandom;
      for (int i = 0; i < NB; i++) lat[i] = $urandom_range(1, 8);
      run_range("rand", a, b);
    end

    // Abort mid-run keeps only the harvested sum
    for (int i = 0; i < NB; i++) lat[i] = $urandom_range(3, 8);
    kmul = $urandom;
    clear_sb();
    pulse_start(0, 39);
    n = 0;
    while (hcnt < 3 && n < 500) begin
      step();
      n++;
    end
    chk("t5_some_harvest", 64'(hcnt >= 3), 64'd1);
    ign = 1'b1;
    es = hsum;
    ec = hcnt;
    cmd_abort = 1'b1;
    step();
    cmd_abort = 1'b0;
    chk("t5_wstart", 64'(wif.w_start), 64'd0);
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_aborted", 64'(aborted), 64'd1);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_total", total_count, es);
    chk("t5_regions", 64'(regions_done), 64'(ec));
    repeat (3) step();
    chk("t5_hold", total_count, es);
    ign = 1'b0;

    // Empty range finishes quickly and clears aborted
    clear_sb();
    pulse_start(9, 3);
    wait_done(10, n);
    chk("t6_fast", 64'(n <= 2), 64'd1);
    chk("t6_total", total_count, 64'd0);
    chk("t6_regions", 64'(regions_done), 64'd0);
    chk("t6_aborted", 64'(aborted), 64'd0);
    chk("t6_ever", 64'(ever), 64'd0);

    // Asynchronous reset in the middle of a run
    for (int i = 0; i < NB; i++) lat[i] = $urandom_range(2, 6);
    pulse_start(0, 30);
    repeat (8) step();
    ign = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_done", 64'(done), 64'd0);
    chk("ar_aborted", 64'(aborted), 64'd0);
    chk("ar_total", total_count, 64'd0);
    chk("ar_regions", 64'(regions_done), 64'd0);
    chk("ar_wstart", 64'(wif.w_start), 64'd0);
    chk("ar_wregion", 64'(wif.w_region), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
